shop_cmd_line_rx: RTL

Upstream feeder for `shop_v`. Receives a byte-serial ASCII stream from the host link and assembles each terminated line into the right-justified, zero-padded command/argument word expected on `shop_v.i_a`. Presents each completed word with a one-cycle `o_rdy` strobe, and holds the selected user number for `shop_v.i_u`. Enforces a minimum gap between strobes so `shop_v` always sees stable, separated inputs.

---
 rtl/shop_cmd_line_rx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/shop_cmd_line_rx.sv
// Line assembler feeding shop_v: collects printable ASCII into a right-justified word,
// strobes it out on CR/LF and handles '#<hex>' user-select lines. SHOP_CMD_LINE_BACKSPACE_EN adds BS/DEL editing.
module shop_cmd_line_rx #(
  parameter int I_A_NUM_ASCII_CHARS = 7,
  parameter int I_U_NUM_BITS        = 4,
  parameter int GAP_CYCLES          = 4
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic [7:0]                       i_byte,
  input  logic                             i_byte_vld,
  output logic                             o_in_rdy,
  output logic [8*I_A_NUM_ASCII_CHARS-1:0] o_a,
  output logic [I_U_NUM_BITS-1:0]          o_u,
  output logic                             o_rdy,
  output logic                             o_err
);

  localparam int N  = I_A_NUM_ASCII_CHARS;
  localparam int AW = 8 * N;
  localparam int CW = $clog2(N + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DISCARD = 2'd1,
    S_COMMIT  = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [AW-1:0]           r_buf, w_buf_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [AW-1:0]           r_a, w_a_nxt;
  logic [I_U_NUM_BITS-1:0] r_u, w_u_nxt;
  logic                    r_rdy, w_rdy_nxt;
  logic                    r_err, w_err_nxt;
  logic [GW-1:0]           r_gap, w_gap_nxt;

  logic       w_accept;
  logic       w_is_print;
  logic       w_is_term;
  logic       w_is_bs;
  logic [7:0] w_first;
  logic       w_hex_ok;
  logic [3:0] w_hex_val;
  state_t     w_after;

  assign o_in_rdy   = (r_state == S_COLLECT) || (r_state == S_DISCARD);
  assign w_accept   = i_byte_vld & o_in_rdy;
  assign w_is_print = (i_byte >= 8'h20) && (i_byte <= 8'h7E);
  assign w_is_term  = (i_byte == 8'h0D) || (i_byte == 8'h0A);
`ifdef SHOP_CMD_LINE_BACKSPACE_EN
  assign w_is_bs    = (i_byte == 8'h08) || (i_byte == 8'h7F);
`else
  assign w_is_bs    = 1'b0;
`endif
  assign w_after    = (GAP_CYCLES == 0) ? S_COLLECT : S_HOLD;

  // Oldest character in the buffer sits at byte (cnt-1).
  always_comb begin
    w_first = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (r_cnt == CW'(i + 1)) w_first = r_buf[8*i +: 8];
    end
  end

  always_comb begin
    w_hex_ok  = 1'b1;
    w_hex_val = 4'h0;
    if (r_buf[7:0] >= 8'h30 && r_buf[7:0] <= 8'h39)      w_hex_val = 4'(r_buf[7:0] - 8'h30);
    else if (r_buf[7:0] >= 8'h41 && r_buf[7:0] <= 8'h46) w_hex_val = 4'(r_buf[7:0] - 8'h37);
    else if (r_buf[7:0] >= 8'h61 && r_buf[7:0] <= 8'h66) w_hex_val = 4'(r_buf[7:0] - 8'h57);
    else                                                 w_hex_ok  = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_COLLECT;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_u_nxt     = r_u;
    w_rdy_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_gap_nxt   = r_gap;
    case (r_state)
      S_COLLECT: begin
        if (w_accept) begin
          if (w_is_print) begin
            if (r_cnt == CW'(N)) begin
              w_state_nxt = S_DISCARD;
            end else begin
              w_buf_nxt = {r_buf[AW-9:0], i_byte};
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else if (w_is_term) begin
            if (r_cnt != '0) begin
              // Strobes and o_a/o_u are registered here so they are valid during COMMIT.
              w_state_nxt = S_COMMIT;
              w_buf_nxt   = '0;
              w_cnt_nxt   = '0;
              if (w_first == 8'h23) begin
                if (r_cnt == CW'(2) && w_hex_ok) w_u_nxt   = w_hex_val[I_U_NUM_BITS-1:0];
                else                             w_err_nxt = 1'b1;
              end else begin
                w_a_nxt   = r_buf;
                w_rdy_nxt = 1'b1;
              end
            end
          end else if (w_is_bs) begin
            if (r_cnt != '0) begin
              w_buf_nxt = r_buf >> 8;
              w_cnt_nxt = r_cnt - CW'(1);
            end
          end else begin
            w_state_nxt = S_DISCARD;
          end
        end
      end
      S_DISCARD: begin
        if (w_accept && w_is_term) begin
          w_err_nxt   = 1'b1;
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = w_after;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      S_COMMIT: begin
        w_state_nxt = w_after;
        w_gap_nxt   = GAP_LOAD;
      end
      S_HOLD: begin
        if (r_gap == '0) w_state_nxt = S_COLLECT;
        else             w_gap_nxt   = r_gap - GW'(1);
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_buf <= '0;
      r_cnt <= '0;
      r_a   <= '0;
      r_u   <= '0;
      r_rdy <= 1'b0;
      r_err <= 1'b0;
      r_gap <= '0;
    end else begin
      r_buf <= w_buf_nxt;
      r_cnt <= w_cnt_nxt;
      r_a   <= w_a_nxt;
      r_u   <= w_u_nxt;
      r_rdy <= w_rdy_nxt;
      r_err <= w_err_nxt;
      r_gap <= w_gap_nxt;
    end
  end

  assign o_a   = r_a;
  assign o_u   = r_u;
  assign o_rdy = r_rdy;
  assign o_err = r_err;

endmodule
